// File: rtl/conv_ctrl_pkg.sv
// Shared constants and types for the 1-D convolution layer controller
// (64 inputs, 33 taps, 16 MAC lanes).
package conv_ctrl_pkg;

    localparam int N   = 64;   // input vector length
    localparam int M   = 33;   // filter taps
    localparam int P   = 16;   // parallel MAC lanes
    localparam int LAT = 2;    // mac_en to accumulator-valid latency of the datapath

    // Number of output groups, each covering P consecutive outputs.
    localparam int G   = (N - M + 1) / P;

    localparam int AW  = $clog2(N);
    localparam int FW  = $clog2(M);
    localparam int LW  = $clog2(P);
    localparam int GW  = (G > 1) ? $clog2(G) : 1;
    localparam int LTW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        WAIT    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Base input-buffer read address for tap k of group g; lane p adds p on top.
    function automatic logic [AW-1:0] rd_base(input logic [GW-1:0] g,
                                              input logic [FW-1:0] k);
        int sum;
        sum = int'(g) * P + int'(k);
        return sum[AW-1:0];
    endfunction

endpackage

// File: rtl/conv_ctrl_64_33_16.sv
// Sequencer for one 1-D convolution layer: loads the input vector into the
// buffer, runs G grouped MAC passes over the filter, waits out the datapath
// latency and drains the P lane results one per transfer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// LOAD    | accepting inputs, writing buffer address wcnt
// COMPUTE | one filter tap per cycle for the current group (k = 0..M-1)
// WAIT    | LAT idle cycles until the accumulators hold final sums
// DRAIN   | presenting lane results 0..P-1 on the output handshake
module conv_ctrl_64_33_16
    import conv_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid_x,
    output logic          s_ready_x,
    output logic          x_wr_en,
    output logic [AW-1:0] x_wr_addr,
    output logic [AW-1:0] x_rd_addr,
    output logic [FW-1:0] f_rd_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic [LW-1:0] out_sel,
    output logic          m_valid_y,
    input  logic          m_ready_y
);

    // The lane count must tile the valid output range exactly.
    if (((N - M + 1) % P) != 0) begin : g_bad_geometry
        $error("conv_ctrl_64_33_16: (N-M+1) must be a multiple of P");
    end

    state_t           state_q;
    state_t           state_d;
    logic [AW-1:0]    wcnt_q;
    logic [FW-1:0]    k_q;
    logic [GW-1:0]    g_q;
    logic [LTW-1:0]   lat_q;
    logic [LW-1:0]    lane_q;

    logic             in_hs;
    logic             out_hs;
    logic             wcnt_last;
    logic             k_last;
    logic             lat_last;
    logic             lane_last;
    logic             g_last;

    assign in_hs     = s_valid_x && (state_q == LOAD);
    assign out_hs    = m_ready_y && (state_q == DRAIN);
    assign wcnt_last = (wcnt_q == AW'(N - 1));
    assign k_last    = (k_q    == FW'(M - 1));
    assign lat_last  = (lat_q  == LTW'(LAT - 1));
    assign lane_last = (lane_q == LW'(P - 1));
    assign g_last    = (g_q    == GW'(G - 1));

    // State register; reset abandons any partial vector or partial results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection from the terminal conditions of each phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (in_hs && wcnt_last) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (k_last) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs && lane_last) begin
                    state_d = g_last ? LOAD : COMPUTE;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Input write counter: advances only on accepted inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q <= '0;
        end else if (in_hs) begin
            wcnt_q <= wcnt_last ? '0 : wcnt_q + 1'b1;
        end
    end

    // Tap counter: one tap per COMPUTE cycle, back to 0 after the last tap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q <= '0;
        end else if (state_q == COMPUTE) begin
            k_q <= k_last ? '0 : k_q + 1'b1;
        end
    end

    // Group counter: cleared when a new vector is complete in the buffer,
    // stepped after each group's final lane leaves, cleared after the last group.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_q <= '0;
        end else if (in_hs && wcnt_last) begin
            g_q <= '0;
        end else if (out_hs && lane_last) begin
            g_q <= g_last ? '0 : g_q + 1'b1;
        end
    end

    // Latency counter: counts the idle cycles between the last tap and the drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_q <= '0;
        end else if (state_q == COMPUTE && k_last) begin
            lat_q <= '0;
        end else if (state_q == WAIT) begin
            lat_q <= lat_last ? '0 : lat_q + 1'b1;
        end
    end

    // Lane counter: advances only on accepted outputs, so backpressure holds it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
        end else if (state_q == WAIT && lat_last) begin
            lane_q <= '0;
        end else if (out_hs) begin
            lane_q <= lane_last ? '0 : lane_q + 1'b1;
        end
    end

    // Output decode from state and counters only; addresses read 0 outside
    // their own phase so idle buses stay quiet.
    always_comb begin
        s_ready_x = 1'b0;
        x_wr_addr = '0;
        x_rd_addr = '0;
        f_rd_addr = '0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        out_sel   = '0;
        m_valid_y = 1'b0;
        case (state_q)
            LOAD: begin
                s_ready_x = 1'b1;
                x_wr_addr = wcnt_q;
            end
            COMPUTE: begin
                mac_en    = 1'b1;
                mac_clr   = (k_q == '0);
                f_rd_addr = k_q;
                x_rd_addr = rd_base(g_q, k_q);
            end
            WAIT: begin
            end
            DRAIN: begin
                m_valid_y = 1'b1;
                out_sel   = lane_q;
            end
            default: begin
            end
        endcase
    end

    // The buffer write strobe is the only output allowed to follow an input directly.
    assign x_wr_en = s_valid_x && s_ready_x;

endmodule
